// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared encodings for the fetch-stage controller.
//   - PC mux select codes (8:1 PC mux)
//   - controller state encodings
//   - pipeline-register flush bit indices
package fetch_ctrl_pkg;

   // PC mux select encodings
   localparam logic [2:0] PCSEL_ZERO     = 3'd0;
   localparam logic [2:0] PCSEL_PIPE3RF  = 3'd1;
   localparam logic [2:0] PCSEL_INC      = 3'd2;
   localparam logic [2:0] PCSEL_DECODE   = 3'd3;
   localparam logic [2:0] PCSEL_PIPE3INC = 3'd4;
   localparam logic [2:0] PCSEL_PIPE2    = 3'd5;
   localparam logic [2:0] PCSEL_PIPE4    = 3'd6;
   localparam logic [2:0] PCSEL_PIPE5    = 3'd7;

   // Controller states
   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_MULTI = 2'd2
   } state_t;

   // Pipeline-register flush bit indices
   localparam int FL_IFID  = 0;
   localparam int FL_IDRR  = 1;
   localparam int FL_RREX  = 2;
   localparam int FL_EXMEM = 3;
   localparam int FL_MEMWB = 4;

endpackage

// File: rtl/redir_prio_enc.sv
// redir_prio_enc: combinational priority encoder for PC-redirect requests.
// The oldest stage wins: pipe5 > pipe4 > pipe3RF > pipe3Inc > pipe2 > decode.
// Ports:
//   reqDecode..reqPipe5  in   redirect requests
//   valid                out  any request present
//   sel                  out  PC mux select for the winner
//   stage                out  winning stage (decode=1 ... pipe5=5), 0 if none
module redir_prio_enc
   import fetch_ctrl_pkg::*;
(
   input  logic       reqDecode,
   input  logic       reqPipe2,
   input  logic       reqPipe3RF,
   input  logic       reqPipe3Inc,
   input  logic       reqPipe4,
   input  logic       reqPipe5,
   output logic       valid,
   output logic [2:0] sel,
   output logic [2:0] stage
);

   always_comb begin
      valid = 1'b1;
      sel   = PCSEL_INC;
      stage = 3'd0;
      if (reqPipe5) begin
         sel = PCSEL_PIPE5;    stage = 3'd5;
      end else if (reqPipe4) begin
         sel = PCSEL_PIPE4;    stage = 3'd4;
      end else if (reqPipe3RF) begin
         sel = PCSEL_PIPE3RF;  stage = 3'd3;
      end else if (reqPipe3Inc) begin
         sel = PCSEL_PIPE3INC; stage = 3'd3;
      end else if (reqPipe2) begin
         sel = PCSEL_PIPE2;    stage = 3'd2;
      end else if (reqDecode) begin
         sel = PCSEL_DECODE;   stage = 3'd1;
      end else begin
         valid = 1'b0;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage controller. Drives the PC mux select and PC write
// enable, arbitrates redirects, sequences boot / hazard stalls / multi-cycle
// holds and produces per-pipeline-register flush and IF/ID hold.
// Ports:
//   clk, reset (async, active-low)
//   redirDecode, redirPipe2, redirPipe3RF, redirPipe3Inc, redirPipe4,
//   redirPipe5                 redirect requests
//   hazardStall                load-use stall
//   multiReq, multiCount       multi-cycle instruction start / hold length
//   PCWrite, pcSelect          PC register enable and PC mux select
//   flush                      pipeline register clears (bit i = register i)
//   holdIF                     IF/ID hold
//   busy                       high in BOOT or MULTI
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int SEL_W = 3,
   parameter int CNT_W = 4,
   parameter int NSTG  = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             redirDecode,
   input  logic             redirPipe2,
   input  logic             redirPipe3RF,
   input  logic             redirPipe3Inc,
   input  logic             redirPipe4,
   input  logic             redirPipe5,
   input  logic             hazardStall,
   input  logic             multiReq,
   input  logic [CNT_W-1:0] multiCount,
   output logic             PCWrite,
   output logic [SEL_W-1:0] pcSelect,
   output logic [NSTG-1:0]  flush,
   output logic             holdIF,
   output logic             busy
);

   state_t           state, nextState;
   logic [CNT_W-1:0] cnt, nextCnt;

   logic             encValid;
   logic [2:0]       encSel;
   logic [2:0]       encStage;
   logic [NSTG-1:0]  redirFlush;

   // Decode's redirect is only honoured in RUN; in MULTI the instruction
   // being held is the one decode is looking at.
   redir_prio_enc uPrio (
      .reqDecode   (redirDecode && (state == ST_RUN)),
      .reqPipe2    (redirPipe2),
      .reqPipe3RF  (redirPipe3RF),
      .reqPipe3Inc (redirPipe3Inc),
      .reqPipe4    (redirPipe4),
      .reqPipe5    (redirPipe5),
      .valid       (encValid),
      .sel         (encSel),
      .stage       (encStage)
   );

   // A redirect from stage s squashes every register younger than s.
   always_comb begin
      redirFlush = '0;
      for (int i = 0; i < NSTG; i++)
         redirFlush[i] = (i < int'(encStage));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_BOOT;
         cnt   <= '0;
      end else begin
         state <= nextState;
         cnt   <= nextCnt;
      end
   end

   always_comb begin
      nextState = state;
      nextCnt   = cnt;
      PCWrite   = 1'b0;
      pcSelect  = SEL_W'(PCSEL_INC);
      flush     = '0;
      holdIF    = 1'b0;
      busy      = 1'b0;

      if (!reset) begin
         // Outputs follow reset directly so they drop without a clock edge.
         nextState = ST_BOOT;
         nextCnt   = '0;
         pcSelect  = SEL_W'(PCSEL_ZERO);
         flush     = '1;
         busy      = 1'b1;
      end else begin
         unique case (state)
            ST_BOOT: begin
               PCWrite   = 1'b1;
               pcSelect  = SEL_W'(PCSEL_ZERO);
               flush     = '1;
               busy      = 1'b1;
               nextState = ST_RUN;
               nextCnt   = '0;
            end
            ST_RUN: begin
               if (encValid) begin
                  PCWrite  = 1'b1;
                  pcSelect = SEL_W'(encSel);
                  flush    = redirFlush;
                  nextCnt  = '0;
               end else if (hazardStall) begin
                  holdIF         = 1'b1;
                  flush[FL_RREX] = 1'b1;
               end else if (multiReq && (multiCount != '0)) begin
                  // First hold cycle is spent in RUN; the rest in MULTI.
                  holdIF    = 1'b1;
                  nextCnt   = multiCount - CNT_W'(1);
                  nextState = (multiCount == CNT_W'(1)) ? ST_RUN : ST_MULTI;
               end else begin
                  PCWrite = 1'b1;
               end
            end
            ST_MULTI: begin
               busy = 1'b1;
               if (encValid) begin
                  PCWrite   = 1'b1;
                  pcSelect  = SEL_W'(encSel);
                  flush     = redirFlush;
                  nextCnt   = '0;
                  nextState = ST_RUN;
               end else begin
                  holdIF = 1'b1;
                  if (cnt <= CNT_W'(1)) begin
                     nextCnt   = '0;
                     nextState = ST_RUN;
                  end else begin
                     nextCnt = cnt - CNT_W'(1);
                  end
               end
            end
            default: begin
               nextState = ST_BOOT;
               nextCnt   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed + randomized checks of fetch_ctrl against a
// behavioural model (boot flag + remaining-hold count).
module tb_fetch_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       redirDecode, redirPipe2, redirPipe3RF, redirPipe3Inc;
   logic       redirPipe4, redirPipe5, hazardStall, multiReq;
   logic [3:0] multiCount;
   logic       PCWrite, holdIF, busy;
   logic [2:0] pcSelect;
   logic [4:0] flush;

   int checks   = 0;
   int failures = 0;

   // model state
   bit booting  = 1'b1;
   int holdLeft = 0;

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk(clk), .reset(reset),
      .redirDecode(redirDecode), .redirPipe2(redirPipe2),
      .redirPipe3RF(redirPipe3RF), .redirPipe3Inc(redirPipe3Inc),
      .redirPipe4(redirPipe4), .redirPipe5(redirPipe5),
      .hazardStall(hazardStall), .multiReq(multiReq), .multiCount(multiCount),
      .PCWrite(PCWrite), .pcSelect(pcSelect), .flush(flush),
      .holdIF(holdIF), .busy(busy)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // r: [0]decode [1]pipe2 [2]pipe3RF [3]pipe3Inc [4]pipe4 [5]pipe5
   task automatic step(input string tag, input bit rl, input logic [5:0] r,
                       input bit hz, input bit mr, input logic [3:0] mc);
      bit         ePCW, eHold, eBusy;
      logic [2:0] eSel;
      logic [4:0] eFl;
      int         win;
      int         stg [6] = '{1, 2, 3, 3, 4, 5};
      int         sel [6] = '{3, 5, 1, 4, 6, 7};
      int         order [6] = '{5, 4, 2, 3, 1, 0};
      bit         inMulti;
      @(negedge clk);
      reset = rl;
      {redirPipe5, redirPipe4, redirPipe3Inc, redirPipe3RF, redirPipe2, redirDecode} = r;
      hazardStall = hz; multiReq = mr; multiCount = mc;
      #1;
      ePCW = 0; eSel = 3'd2; eFl = 5'd0; eHold = 0; eBusy = 0;
      inMulti = (holdLeft > 0);
      if (!rl) begin
         eSel = 0; eFl = 5'b11111; eBusy = 1;
         booting = 1; holdLeft = 0;
      end else if (booting) begin
         ePCW = 1; eSel = 0; eFl = 5'b11111; eBusy = 1;
         booting = 0;
      end else begin
         win = -1;
         for (int k = 0; k < 6; k++)
            if (win < 0 && r[order[k]] && !(inMulti && order[k] == 0)) win = order[k];
         eBusy = inMulti;
         if (win >= 0) begin
            ePCW = 1; eSel = 3'(sel[win]); eFl = 5'((1 << stg[win]) - 1);
            holdLeft = 0;
         end else if (inMulti) begin
            eHold = 1; holdLeft--;
         end else if (hz) begin
            eHold = 1; eFl = 5'b00100;
         end else if (mr && mc != 0) begin
            eHold = 1; holdLeft = int'(mc) - 1;
         end else begin
            ePCW = 1;
         end
      end
      chk({tag, ".PCWrite"},  8'(PCWrite),  8'(ePCW));
      chk({tag, ".pcSelect"}, 8'(pcSelect), 8'(eSel));
      chk({tag, ".flush"},    8'(flush),    8'(eFl));
      chk({tag, ".holdIF"},   8'(holdIF),   8'(eHold));
      chk({tag, ".busy"},     8'(busy),     8'(eBusy));
   endtask

   initial begin
      reset = 0;
      {redirPipe5, redirPipe4, redirPipe3Inc, redirPipe3RF, redirPipe2, redirDecode} = '0;
      hazardStall = 0; multiReq = 0; multiCount = 0;

      step("rst0",   0, 6'h00, 0, 0, 0);
      step("rst1",   0, 6'h3f, 1, 1, 4'd3);   // requests ignored in reset
      step("boot",   1, 6'h3f, 1, 1, 4'd3);   // and in BOOT
      step("run",    1, 6'h00, 0, 0, 0);
      step("dec+p4", 1, 6'h11, 0, 0, 0);
      step("inc",    1, 6'h00, 0, 0, 0);
      step("haz1",   1, 6'h00, 1, 0, 0);
      step("haz2",   1, 6'h00, 1, 0, 0);
      step("inc2",   1, 6'h00, 0, 0, 0);
      step("m3run",  1, 6'h00, 0, 1, 4'd3);
      step("m3a",    1, 6'h00, 1, 1, 4'd7);   // ignored in MULTI
      step("m3b",    1, 6'h01, 0, 0, 0);      // decode ignored in MULTI
      step("m3done", 1, 6'h00, 0, 0, 0);
      step("m5run",  1, 6'h00, 0, 1, 4'd5);
      step("m5a",    1, 6'h00, 0, 0, 0);
      step("m5abrt", 1, 6'h05, 0, 0, 0);      // pipe3RF + decode
      step("m5post", 1, 6'h00, 0, 0, 0);
      step("m0",     1, 6'h00, 0, 1, 4'd0);
      step("m1",     1, 6'h00, 0, 1, 4'd1);
      step("m1post", 1, 6'h00, 0, 0, 0);
      step("p5win",  1, 6'h3f, 1, 1, 4'd2);
      step("p3inc",  1, 6'h0b, 0, 0, 0);
      step("p2",     1, 6'h03, 1, 0, 0);
      step("m4run",  1, 6'h00, 0, 1, 4'd4);
      step("m4a",    1, 6'h00, 0, 0, 0);
      step("arst",   0, 6'h00, 0, 0, 0);      // async reset mid-MULTI
      step("boot2",  1, 6'h00, 0, 0, 0);
      step("run2",   1, 6'h00, 0, 0, 0);

      for (int n = 0; n < 400; n++) begin
         logic [5:0] r;
         for (int b = 0; b < 6; b++) r[b] = ($urandom_range(0, 7) == 0);
         step("rnd", ($urandom_range(0, 59) != 0), r,
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
              4'($urandom_range(0, 15)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Controller for the fetch stage. Each cycle it produces the 3-bit PC-source select and the PC write enable for the fetch stage's 8:1 PC mux and PC register.
- Arbitrates PC-redirect requests from decode and pipe stages 2–5, with the oldest stage winning.
- Sequences the post-reset boot load, hazard stalls and multi-cycle (LM/SM) holds.
- Emits per-pipeline-register flush and hold controls.

Parameters:
- SEL_W, 3, width of the PC-source select (matches the 8-input PC mux).
- CNT_W, 4, width of the multi-cycle hold counter.
- NSTG, 5, number of pipeline registers under flush control (IF/ID=0 … MEM/WB=4).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- redirDecode  in  1  decode requests PC := decode target.
- redirPipe2  in  1  stage 2 requests PC := pipe2 target.
- redirPipe3RF  in  1  stage 3 requests PC := register-file value (JLR).
- redirPipe3Inc  in  1  stage 3 requests PC := PC+1 of that instruction (branch not taken after mispredict).
- redirPipe4  in  1  stage 4 requests PC := pipe4 target (branch taken).
- redirPipe5  in  1  stage 5 requests PC := writeback value (R7 write).
- hazardStall  in  1  load-use stall from the hazard unit.
- multiReq  in  1  decode starts a multi-cycle instruction.
- multiCount  in  CNT_W  number of hold cycles for that instruction.
- PCWrite  out  1  PC register write enable.
- pcSelect  out  SEL_W  PC mux select.
  - Encoding: 0 = zero, 1 = pipe3RF, 2 = PC+1, 3 = decode, 4 = pipe3Inc, 5 = pipe2, 6 = pipe4, 7 = pipe5.
- flush  out  NSTG  synchronous clear of pipeline registers, bit i = register i.
- holdIF  out  1  IF/ID register hold (write disable).
- busy  out  1  high while in BOOT or MULTI.

Behaviour:
- States: RESET/BOOT, RUN, MULTI. The state register and counter reset asynchronously.
- Outputs are combinational from state, counter and request inputs (Mealy). A redirect is therefore seen by the PC register on the same edge it is requested.
- While reset=0:
  - state=BOOT, cnt=0.
  - Outputs: PCWrite=0, pcSelect=0, flush=5'b11111, holdIF=0, busy=1.
- BOOT, first cycle after reset release:
  - PCWrite=1, pcSelect=0 (PC := 0), flush=all ones, busy=1.
  - All request inputs are ignored.
  - Next state is RUN.
- RUN, evaluated in priority order:
  1. Redirect priority: pipe5 > pipe4 > pipe3RF > pipe3Inc > pipe2 > decode.
     - Winner of stage s (decode s=1, pipe2 s=2, pipe3 s=3, pipe4 s=4, pipe5 s=5): PCWrite=1, pcSelect per encoding, flush bits [s-1:0]=1 and the rest 0, holdIF=0.
     - A redirect overrides hazardStall and multiReq in the same cycle; multiReq is discarded.
  2. Else if hazardStall: PCWrite=0, holdIF=1, flush=5'b00100 (bubble into RR/EX), pcSelect=2.
  3. Else if multiReq and multiCount≠0:
     - PCWrite=0, holdIF=1, flush=0, pcSelect=2.
     - cnt := multiCount−1. If multiCount=1, stay in RUN; otherwise go to MULTI.
  4. Else (multiReq with multiCount=0 is treated as no request): PCWrite=1, pcSelect=2, flush=0, holdIF=0.
- MULTI:
  - Default outputs: PCWrite=0, holdIF=1, flush=0, busy=1.
  - When cnt=1, the next state is RUN; otherwise cnt decrements.
  - redirDecode, hazardStall and multiReq are ignored.
  - A redirect from stage ≥2 aborts MULTI: outputs follow the RUN redirect rule, cnt := 0, next state RUN.
- pcSelect is 2 whenever PCWrite=0, except in reset/BOOT where it is 0.
- Reset asserted mid-MULTI or mid-redirect: immediate return to the reset values above, including the counter.

Decomposition:
- Shared package / defines file holds:
  - PC-select encodings (PCSEL_ZERO … PCSEL_PIPE5).
  - State encodings (ST_BOOT, ST_RUN, ST_MULTI).
  - Pipeline-register flush bit indices.
- One natural sub-module: redir_prio_enc. It is a combinational 6-input priority encoder returning {valid, pcSelect, stage index}, reusable by the bench's reference model.

Test Plan:
- Reset release → cycle 1: PCWrite=1, pcSelect=0, flush=11111. Cycle 2: PCWrite=1, pcSelect=2, flush=00000, busy=0.
- RUN, redirDecode and redirPipe4 both asserted → pcSelect=6, PCWrite=1, flush=01111. Next cycle with no requests: pcSelect=2.
- hazardStall for 2 cycles → PCWrite=0 and holdIF=1 for 2 cycles, flush=00100 each cycle, then normal increment.
- multiReq with multiCount=3 → PCWrite=0 and holdIF=1 for exactly 3 cycles (1 in RUN, 2 in MULTI), busy=1 during MULTI, then PCWrite=1 with pcSelect=2.
- multiCount=5; at the 2nd MULTI cycle redirPipe3RF=1 → pcSelect=1, flush=00111, PCWrite=1, back to RUN next cycle. A simultaneous redirDecode in MULTI is ignored.
- reset driven low asynchronously mid-MULTI (between edges) → outputs take reset values immediately, without waiting for a clock edge. After release, the BOOT sequence repeats with PC := 0.
